pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 4, is the pattern length in bits; the legal range is 2..16.
REQ-002 Parameter PATTERN, default 4'b1101, is the target sequence; its MSB is received first.
REQ-003 Parameter OVERLAP, default 1: 1 allows overlapping matches, 0 restarts the search after each match.
REQ-004 Parameter CNT_W, default 8, is the width of the match counter.
REQ-005 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  is the asynchronous, active-high reset.
REQ-007 P1  input  1  is the serial data bit, sampled on a rising clk edge when en=1.
REQ-008 en  input  1  is the sample enable; en=0 holds all state.
REQ-009 z  output  1  is the Moore match flag, decoded from the state register only.
REQ-010 state_o  output  $clog2(PAT_LEN+1)  is the current state, for debug.
REQ-011 match_count  output  CNT_W  is the saturating count of matches.

Function
REQ-012 States S0..S_PAT_LEN SHALL exist, where Sk means "the first k pattern bits are matched".
REQ-013 z SHALL be 1 if and only if the state is S_PAT_LEN; z SHALL have no combinational path from P1 or en.
REQ-014 On an enabled edge with OVERLAP=1, next state SHALL be the longest k such that pattern[first k bits] equals the suffix of (matched bits + P1); this includes the transition out of S_PAT_LEN.
REQ-015 On an enabled edge with OVERLAP=0, the state out of S_PAT_LEN SHALL be S1 if P1 equals the pattern MSB, else S0; all other states follow REQ-014.
REQ-016 Failure transitions SHALL be derived from PATTERN at elaboration time; hard-coded tables for a single pattern are not allowed.
REQ-017 Latency: z SHALL assert in the cycle after the edge that samples the last pattern bit, and SHALL last exactly one cycle unless the next enabled sample re-enters S_PAT_LEN.
REQ-018 When en=0, state, z and match_count SHALL hold their values; a held S_PAT_LEN keeps z=1.
REQ-019 match_count SHALL increment by 1 on each entry into S_PAT_LEN and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-020 Reset asserted mid-pattern SHALL discard the partial match; the first post-reset bit is treated as a fresh start.

Reset
REQ-021 Asynchronous reset SHALL force state=S0, z=0, state_o=0, match_count=0 immediately, without waiting for a clk edge.
REQ-022 Reset release SHALL take effect at the next rising clk edge; no sample SHALL be taken during reset.

Configuration
REQ-023 With macro PATTERN_DETECTOR_COUNT_EN defined, the match_count logic of REQ-019 SHALL be present.
REQ-024 Without PATTERN_DETECTOR_COUNT_EN, match_count SHALL be tied to 0, with no counter flops; all other behaviour is unchanged.

Verification
REQ-025 Reset pulse, then default parameters, en=1, stream 0,1,1,0,1,1,0,0,1,0,1,1,0,0,1 -> exactly one z pulse, in the cycle after the 5th bit; match_count=1.
REQ-026 OVERLAP=1, stream 1,1,0,1,1,0,1 -> z pulses after bit 4 and after bit 7; match_count=2.
REQ-027 OVERLAP=0, same stream as REQ-026 -> z pulses after bit 4 only; match_count=1.
REQ-028 Stream 1,1,0 with en=1, then en=0 for 3 cycles with P1 toggling, then en=1 and P1=1 -> state holds at S3 while en=0, then z=1 after the final bit.
REQ-029 Stream 1,1,0, then reset asserted between clk edges -> state_o=0 and z=0 immediately; a following 1 moves the state to S1 only.
REQ-030 CNT_W=2 with PATTERN_DETECTOR_COUNT_EN defined, 5 matches -> match_count saturates at 3; without the macro, match_count stays 0 throughout.

Source files
------------

// File: rtl/pattern_detector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pattern_detector: Moore serial pattern detector with match counter         |
// | Optional counter enabled by macro PATTERN_DETECTOR_COUNT_EN                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           P1,
  input  logic                           en,
  output logic                           z,
  output logic [$clog2(PAT_LEN+1)-1:0]   state_o,
  output logic [CNT_W-1:0]               match_count
);

  localparam int            SW     = $clog2(PAT_LEN + 1);
  localparam logic [SW-1:0] S0     = '0;
  localparam logic [SW-1:0] S_FULL = SW'(PAT_LEN);

  // Pattern bit at position idx counted from the first-received (MSB) end.
  function automatic logic pat_bit(input int idx);
    logic [PAT_LEN-1:0] t;
    t = PATTERN >> (PAT_LEN - 1 - idx);
    return t[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  function automatic int calc_next(input int k, input logic b);
    int   best;
    int   s;
    logic ok;
    logic sb;
    best = 0;
    if (OVERLAP == 0 && k == PAT_LEN) begin
      best = (b == pat_bit(0)) ? 1 : 0;
    end else begin
      for (int j = 1; j <= PAT_LEN; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++) begin
            s = k + 1 - j + i;
            if (s < k) sb = pat_bit(s);
            else       sb = b;
            if (sb != pat_bit(i)) ok = 1'b0;
          end
          if (ok) best = j;
        end
      end
    end
    return best;
  endfunction

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;
  logic [SW-1:0] w_nxt0 [PAT_LEN+1];
  logic [SW-1:0] w_nxt1 [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_trans
    localparam logic [SW-1:0] N0 = SW'(calc_next(k, 1'b0));
    localparam logic [SW-1:0] N1 = SW'(calc_next(k, 1'b1));
    assign w_nxt0[k] = N0;
    assign w_nxt1[k] = N1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (en) begin
      w_next = S0;
      for (int k = 0; k <= PAT_LEN; k++) begin
        if (r_state == SW'(k)) w_next = P1 ? w_nxt1[k] : w_nxt0[k];
      end
    end
  end

  always_comb begin
    z       = (r_state == S_FULL);
    state_o = r_state;
  end

`ifdef PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Every enabled edge landing in S_FULL is a new match, including self-loops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (en && (w_next == S_FULL) && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + CNT_W'(1);
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pattern_detector: scoreboard bench for pattern_detector (1101)          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       reset, P1, en;
  logic       z0, z1, z2;
  logic [2:0] s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  pattern_detector #(.OVERLAP(1), .CNT_W(8)) u_ovl (
    .clk(clk), .reset(reset), .P1(P1), .en(en), .z(z0), .state_o(s0), .match_count(c0));
  pattern_detector #(.OVERLAP(0), .CNT_W(8)) u_novl (
    .clk(clk), .reset(reset), .P1(P1), .en(en), .z(z1), .state_o(s1), .match_count(c1));
  pattern_detector #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .P1(P1), .en(en), .z(z2), .state_o(s2), .match_count(c2));

  always #5 clk = ~clk;

  typedef struct {
    int s0; int z0; int c0;
    int s1; int z1; int c1;
    int s2; int z2; int c2;
  } exp_t;

  exp_t sb[$];
  bit   patb[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit   ha[$];
  bit   hb[$];
  int   sa, sbst, ca, cb, cc;
  int   errors = 0;
  int   checks = 0;
  int   zp0, zp1, first_z;

  // Longest suffix of the received history equal to a pattern prefix.
  function automatic int pstate(input bit h[$]);
    bit ok;
    for (int k = 4; k >= 1; k--) begin
      if (h.size() >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[h.size() - k + i] != patb[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic int expc(input int v);
`ifdef PATTERN_DETECTOR_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ha.delete();
    hb.delete();
    sa = 0; sbst = 0; ca = 0; cb = 0; cc = 0;
  endtask

  task automatic model_step(input bit b);
    ha.push_back(b);
    if (ha.size() > 4) void'(ha.pop_front());
    sa = pstate(ha);
    if (sa == 4 && ca < 255) ca++;
    if (sa == 4 && cc < 3) cc++;
    if (sbst == 4) hb.delete();
    hb.push_back(b);
    if (hb.size() > 4) void'(hb.pop_front());
    sbst = pstate(hb);
    if (sbst == 4 && cb < 255) cb++;
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("ovl_state", int'(s0), e.s0);
      check("ovl_z", int'(z0), e.z0);
      check("ovl_count", int'(c0), e.c0);
      check("novl_state", int'(s1), e.s1);
      check("novl_z", int'(z1), e.z1);
      check("novl_count", int'(c1), e.c1);
      check("sat_state", int'(s2), e.s2);
      check("sat_z", int'(z2), e.z2);
      check("sat_count", int'(c2), e.c2);
    end
    if (z0) zp0++;
    if (z1) zp1++;
  endtask

  task automatic drive(input bit b, input bit e);
    exp_t x;
    @(negedge clk);
    P1 = b;
    en = e;
    if (e) model_step(b);
    x.s0 = sa;   x.z0 = int'(sa == 4);   x.c0 = expc(ca);
    x.s1 = sbst; x.z1 = int'(sbst == 4); x.c1 = expc(cb);
    x.s2 = sa;   x.z2 = int'(sa == 4);   x.c2 = expc(cc);
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_imm_state", int'(s0), 0);
    check("rst_imm_z", int'(z0), 0);
    check("rst_imm_count", int'(c0), 0);
    check("rst_imm_novl_state", int'(s1), 0);
    check("rst_imm_sat_count", int'(c2), 0);
    model_reset();
    @(negedge clk);
    P1 = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_no_sample", int'(s0), 0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
  endtask

  initial begin
    bit st25[15] = '{0,1,1,0,1,1,0,0,1,0,1,1,0,0,1};
    bit st26[7]  = '{1,1,0,1,1,0,1};

    reset = 1'b1;
    P1    = 1'b0;
    en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", int'(s0), 0);
    check("reset_z", int'(z0), 0);
    check("reset_count", int'(c0), 0);
    @(negedge clk);
    reset = 1'b0;

    zp0 = 0; zp1 = 0; first_z = -1;
    for (int i = 0; i < 15; i++) begin
      drive(st25[i], 1'b1);
      if (z0 && first_z < 0) first_z = i;
    end
    check("s25_pulses", zp0, 1);
    check("s25_pulse_bit", first_z, 4);
    check("s25_count", int'(c0), expc(1));

    async_reset();
    zp0 = 0; zp1 = 0;
    for (int i = 0; i < 7; i++) drive(st26[i], 1'b1);
    check("ovl_pulses", zp0, 2);
    check("novl_pulses", zp1, 1);
    check("ovl_total", int'(c0), expc(2));
    check("novl_total", int'(c1), expc(1));

    async_reset();
    drive(1, 1); drive(1, 1); drive(0, 1);
    drive(0, 0); drive(1, 0); drive(0, 0);
    check("hold_s3", int'(s0), 3);
    drive(1, 1);
    check("z_after_hold", int'(z0), 1);
    drive(0, 0);
    check("held_full_z", int'(z0), 1);

    async_reset();
    drive(1, 1); drive(1, 1); drive(0, 1);
    check("partial_s3", int'(s0), 3);
    async_reset();
    drive(1, 1);
    check("post_reset_s1", int'(s0), 1);

    async_reset();
    drive(1, 1); drive(1, 1); drive(0, 1); drive(1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1); drive(0, 1); drive(1, 1);
    end
    check("sat_final", int'(c2), expc(3));
    check("wide_final", int'(c0), expc(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
